sim_exit_monitor: RTL and testbench

- Synthesizable end-of-test monitor that snoops the data-memory write port of the pipelined CPU.
- Decodes riscv-tests style tohost writes into pass/fail status, with a parametrised cycle watchdog and cycle/retire counters.
- Buffers console bytes written to a memory-mapped address in a drainable FIFO.
- Replaces bench-only timeout and tohost logic so the same check runs in simulation and on the board (LED/UART).

---
 rtl/sim_exit_monitor_if.sv | 34 +++
 rtl/sim_exit_monitor.sv | 145 ++++++++++++++
 tb/tb_sim_exit_monitor.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sim_exit_monitor_if.sv
// Snoop bus between the CPU-side environment and sim_exit_monitor: memory-port snoop inputs,
// console FIFO drain handshake and end-of-test status.
interface sim_exit_monitor_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             dmem_we;
  logic [31:0]      dmem_addr;
  logic [31:0]      dmem_wdata;
  logic             retire;
  logic [31:0]      imem_addr;
  logic             con_valid;
  logic [7:0]       con_data;
  logic             con_ready;
  logic             con_overflow;
  logic             done;
  logic             pass;
  logic             timeout;
  logic [30:0]      fail_code;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] retire_count;

  modport master (
    output start, dmem_we, dmem_addr, dmem_wdata, retire, imem_addr, con_ready,
    input  con_valid, con_data, con_overflow, done, pass, timeout, fail_code,
           cycle_count, retire_count
  );

  modport slave (
    input  start, dmem_we, dmem_addr, dmem_wdata, retire, imem_addr, con_ready,
    output con_valid, con_data, con_overflow, done, pass, timeout, fail_code,
           cycle_count, retire_count
  );
endinterface

// File: rtl/sim_exit_monitor.sv
// End-of-test monitor: tohost pass/fail decode, cycle watchdog, counters and console FIFO.
// Optional hang detection on a stuck fetch PC is enabled by defining SIM_EXIT_HANG_DETECT_EN.
module sim_exit_monitor #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter logic [31:0] CONSOLE_ADDR   = 32'h0000_1004,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter int          CNT_W          = 32,
  parameter int          CON_DEPTH      = 16,
  parameter int          HANG_CYCLES    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  sim_exit_monitor_if.slave bus
);

  localparam int AW = $clog2(CON_DEPTH);
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_cycleCount;
  logic [CNT_W-1:0] r_retireCount;
  logic [30:0]      r_failCode;
  logic [7:0]       r_mem [CON_DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic             r_overflow;

  logic w_inRun;
  logic w_tohostWr;
  logic w_conWr;
  logic w_wdogHit;
  logic w_hangHit;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_inRun    = (r_state == S_RUN);
  assign w_tohostWr = w_inRun && bus.dmem_we && (bus.dmem_addr == TOHOST_ADDR);
  assign w_conWr    = w_inRun && bus.dmem_we && (bus.dmem_addr == CONSOLE_ADDR);
  assign w_wdogHit  = w_inRun && (TIMEOUT_CYCLES != 0) && (r_cycleCount == WDOG_LAST);

`ifdef SIM_EXIT_HANG_DETECT_EN
  localparam int STALL_W = $clog2(HANG_CYCLES + 1);

  logic [31:0]        r_prevImem;
  logic [STALL_W-1:0] r_stall;
  logic [STALL_W-1:0] w_runLen;

  // r_stall == 0 marks the first RUN cycle, which always starts a fresh run of length 1
  assign w_runLen  = ((bus.imem_addr != r_prevImem) || (r_stall == '0)) ?
                     STALL_W'(1) : r_stall + STALL_W'(1);
  assign w_hangHit = w_inRun && (w_runLen == STALL_W'(HANG_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prevImem <= '0;
      r_stall    <= '0;
    end else begin
      r_prevImem <= bus.imem_addr;
      r_stall    <= w_inRun ? w_runLen : '0;
    end
  end
`else
  assign w_hangHit = 1'b0 && (HANG_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // tohost beats watchdog, watchdog beats hang detection
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_nextState = S_RUN;
      S_RUN: begin
        if (w_tohostWr) begin
          w_nextState = (bus.dmem_wdata == 32'd1) ? S_PASS : S_FAIL;
        end else if (w_wdogHit || w_hangHit) begin
          w_nextState = S_TIMEOUT;
        end
      end
      default: w_nextState = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycleCount  <= '0;
      r_retireCount <= '0;
      r_failCode    <= '0;
    end else if (w_inRun) begin
      if (!(&r_cycleCount)) r_cycleCount <= r_cycleCount + 1'b1;
      if (bus.retire && !(&r_retireCount)) r_retireCount <= r_retireCount + 1'b1;
      if (w_tohostWr && (bus.dmem_wdata != 32'd1)) r_failCode <= bus.dmem_wdata[31:1];
    end
  end

  // Extra pointer MSB distinguishes full from empty; a same-cycle pop frees room for the push
  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_pop   = !w_empty && bus.con_ready;
  assign w_push  = w_conWr && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop) r_rdPtr <= r_rdPtr + 1'b1;
      if (w_conWr && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr[AW-1:0]] <= bus.dmem_wdata[7:0];
  end

  assign bus.con_valid    = !w_empty;
  assign bus.con_data     = w_empty ? 8'h00 : r_mem[r_rdPtr[AW-1:0]];
  assign bus.con_overflow = r_overflow;
  assign bus.done         = (r_state == S_PASS) || (r_state == S_FAIL) || (r_state == S_TIMEOUT);
  assign bus.pass         = (r_state == S_PASS);
  assign bus.timeout      = (r_state == S_TIMEOUT);
  assign bus.fail_code    = r_failCode;
  assign bus.cycle_count  = r_cycleCount;
  assign bus.retire_count = r_retireCount;

endmodule

// File: tb/tb_sim_exit_monitor.sv
// Bench for sim_exit_monitor: directed scenarios plus randomized episodes checked against an
// event-level reference model of the end-of-test rules.
module tb_sim_exit_monitor;

  localparam int          TO      = 100;
  localparam int          DEPTH   = 4;
  localparam int          HANG    = 8;
  localparam logic [31:0] TOHOST  = 32'h0000_1000;
  localparam logic [31:0] CONSOLE = 32'h0000_1004;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sim_exit_monitor_if #(.CNT_W(32)) bus();

  sim_exit_monitor #(
    .TOHOST_ADDR(TOHOST), .CONSOLE_ADDR(CONSOLE), .TIMEOUT_CYCLES(TO),
    .CNT_W(32), .CON_DEPTH(DEPTH), .HANG_CYCLES(HANG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int nCompared = 0;
  int nMismatch = 0;
  bit holdPc    = 1'b0;

  // Reference model: "running"/"ended" flags plus outcome, a byte queue for the console
  bit          mRun, mEnd, mPass, mTo, mOvf;
  logic [30:0] mCode;
  logic [31:0] mCyc, mRet, mLastPc;
  int          mRunLen;
  logic [7:0]  mQ[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatch++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelEdge();
    logic [31:0] prevCyc;
    bit          conW;
    if (rst) begin
      mRun = 0; mEnd = 0; mPass = 0; mTo = 0; mOvf = 0;
      mCode = '0; mCyc = '0; mRet = '0; mLastPc = '0; mRunLen = 0;
      mQ.delete();
      return;
    end
    conW = mRun && bus.dmem_we && (bus.dmem_addr == CONSOLE);
    if (mQ.size() > 0 && bus.con_ready) void'(mQ.pop_front());
    if (conW) begin
      if (mQ.size() < DEPTH) mQ.push_back(bus.dmem_wdata[7:0]);
      else mOvf = 1;
    end
    if (!mRun && !mEnd) begin
      if (bus.start) begin mRun = 1; mRunLen = 0; end
    end else if (mRun) begin
      prevCyc = mCyc;
      if (mCyc != 32'hFFFF_FFFF) mCyc++;
      if (bus.retire && mRet != 32'hFFFF_FFFF) mRet++;
      mRunLen = (mRunLen == 0 || bus.imem_addr != mLastPc) ? 1 : mRunLen + 1;
      if (bus.dmem_we && bus.dmem_addr == TOHOST) begin
        mRun = 0; mEnd = 1;
        if (bus.dmem_wdata == 32'd1) mPass = 1;
        else mCode = bus.dmem_wdata[31:1];
      end else if (prevCyc == TO - 1) begin
        mRun = 0; mEnd = 1; mTo = 1;
      end
`ifdef SIM_EXIT_HANG_DETECT_EN
      else if (mRunLen >= HANG) begin
        mRun = 0; mEnd = 1; mTo = 1;
      end
`endif
    end
    mLastPc = bus.imem_addr;
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    #1;
    if (!holdPc) bus.imem_addr = $urandom;
  endtask

  task automatic checkOutput();
    check("done",        bus.done,         mEnd);
    check("pass",        bus.pass,         mPass);
    check("timeout",     bus.timeout,      mTo);
    check("fail_code",   bus.fail_code,    mCode);
    check("cycle_count", bus.cycle_count,  mCyc);
    check("retire_cnt",  bus.retire_count, mRet);
    check("con_valid",   bus.con_valid,    mQ.size() > 0);
    check("con_data",    bus.con_data,     (mQ.size() > 0) ? mQ[0] : 8'h00);
    check("con_ovf",     bus.con_overflow, mOvf);
  endtask

  task automatic tick();
    applyStimulus();
    checkOutput();
  endtask

  task automatic quiet();
    bus.start = 0; bus.dmem_we = 0; bus.dmem_addr = '0; bus.dmem_wdata = '0;
    bus.retire = 0; bus.con_ready = 0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.dmem_we = 1; bus.dmem_addr = addr; bus.dmem_wdata = data;
  endtask

  task automatic resetAndStart();
    quiet(); rst = 1; tick(); rst = 0;
    bus.start = 1; tick(); bus.start = 0;
  endtask

  initial begin
    logic [9:0] retPat;
    logic [7:0] bytes;
    int         r;
    quiet();
    bus.imem_addr = '0;
    rst = 1;
    tick(); tick();
    check("rst_done", bus.done, 1'b0);
    check("rst_cnt",  bus.cycle_count, 32'd0);
    rst = 0;

    // Pass with counters
    bus.start = 1; tick(); bus.start = 0;
    retPat = 10'b10_1101_1101;
    for (int i = 0; i < 10; i++) begin bus.retire = retPat[i]; tick(); end
    bus.retire = 0; wr(TOHOST, 32'd1); tick(); quiet();
    check("p_done", bus.done, 1'b1);
    check("p_pass", bus.pass, 1'b1);
    check("p_code", bus.fail_code, 31'd0);
    check("p_cyc",  bus.cycle_count, 32'd11);
    check("p_ret",  bus.retire_count, 32'd7);
    bus.start = 1; tick(); tick(); bus.start = 0;
    check("p_hold", bus.pass, 1'b1);

    // Fail code, later tohost write ignored
    resetAndStart();
    tick(); tick();
    wr(TOHOST, 32'h0000_0007); tick(); quiet();
    check("f_done", bus.done, 1'b1);
    check("f_pass", bus.pass, 1'b0);
    check("f_code", bus.fail_code, 31'd3);
    wr(TOHOST, 32'd1); tick(); quiet(); tick();
    check("f_sticky", bus.fail_code, 31'd3);
    check("f_nopass", bus.pass, 1'b0);
    resetAndStart();
    wr(TOHOST, 32'd0); tick(); quiet();
    check("f_zero_done", bus.done, 1'b1);
    check("f_zero_pass", bus.pass, 1'b0);

    // Watchdog fires exactly TO cycles after entering RUN
    resetAndStart();
    for (int i = 0; i < TO - 1; i++) tick();
    check("w_early", bus.done, 1'b0);
    tick();
    check("w_to",   bus.timeout, 1'b1);
    check("w_done", bus.done, 1'b1);
    check("w_cyc",  bus.cycle_count, 32'(TO));
    // tohost in the last cycle wins
    resetAndStart();
    for (int i = 0; i < TO - 1; i++) tick();
    wr(TOHOST, 32'd1); tick(); quiet();
    check("w_tpass", bus.pass, 1'b1);
    check("w_tto",   bus.timeout, 1'b0);

    // Console FIFO overflow and drain
    resetAndStart();
    for (int i = 0; i < 5; i++) begin wr(CONSOLE, 32'h41 + i); tick(); end
    quiet();
    check("c_ovf",  bus.con_overflow, 1'b1);
    check("c_head", bus.con_data, 8'h41);
    bus.con_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check("c_drain", bus.con_data, 8'(8'h41 + i));
      tick();
    end
    check("c_empty", bus.con_valid, 1'b0);
    // Full with same-cycle pop accepts the push
    resetAndStart();
    for (int i = 0; i < 4; i++) begin wr(CONSOLE, 32'h61 + i); tick(); end
    bus.con_ready = 1; wr(CONSOLE, 32'h7A); tick(); quiet();
    check("c_pp_ovf",  bus.con_overflow, 1'b0);
    check("c_pp_head", bus.con_data, 8'h62);
    wr(CONSOLE, 32'h31); tick(); wr(TOHOST, 32'd1); tick(); quiet();
    bus.con_ready = 1;
    for (int i = 0; i < 6; i++) tick();
    check("c_term_empty", bus.con_valid, 1'b0);

    // Reset mid-run discards FIFO and counters
    resetAndStart();
    for (int i = 0; i < 3; i++) begin wr(CONSOLE, 32'h50 + i); tick(); end
    quiet();
    for (int i = 0; i < 200 && mCyc != 32'd50; i++) begin bus.retire = 1'($urandom); tick(); end
    check("m_cyc50", bus.cycle_count, 32'd50);
    quiet(); rst = 1; tick(); rst = 0;
    check("m_valid", bus.con_valid, 1'b0);
    check("m_cyc",   bus.cycle_count, 32'd0);
    wr(CONSOLE, 32'h58); tick(); quiet(); tick();
    check("m_idle_wr", bus.con_valid, 1'b0);

    // Randomized episodes
    for (int ep = 0; ep < 12; ep++) begin
      quiet(); rst = 1; tick(); rst = 0;
      for (int c = 0; c < 150; c++) begin
        r = $urandom_range(0, 99);
        bytes = 8'($urandom);
        quiet();
        bus.start     = (c > 3) ? 1'($urandom) : 1'b0;
        bus.retire    = 1'($urandom);
        bus.con_ready = ($urandom_range(0, 3) == 0);
        if (r < 15) wr(CONSOLE, {24'($urandom), bytes});
        else if (r < 18) wr(TOHOST, ($urandom_range(0, 1) == 1) ? 32'd1 : $urandom);
        else if (r < 28) wr(32'h0000_1008, $urandom);
        tick();
      end
    end

`ifdef SIM_EXIT_HANG_DETECT_EN
    holdPc = 1; bus.imem_addr = 32'h40;
    resetAndStart();
    for (int i = 0; i < HANG - 1; i++) tick();
    check("h_early", bus.done, 1'b0);
    tick();
    check("h_to", bus.timeout, 1'b1);
    resetAndStart();
    for (int i = 0; i < 40; i++) begin
      bus.imem_addr = ((i / 5) % 2 == 0) ? 32'h40 : 32'h44;
      tick();
    end
    check("h_toggle", bus.done, 1'b0);
    holdPc = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
